// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - instruction fetch handshake between pc_unit and instruction memory
interface pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack
  );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with fetch stall, branch/jump/jalr redirect and misaligned-target trap
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_unit_if.master   imem,
  input  logic        BrTaken,
  input  logic        Jump,
  input  logic        Jalr,
  input  logic [31:0] Imm,
  input  logic [31:0] RS1,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic        instr_valid,
  output logic        trap,
  output logic [31:0] trap_pc,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc_next;
  logic [31:0] trap_pc_next;
  logic [31:0] retired_next;
  logic [31:0] target;
  logic [31:0] jalr_sum;
  logic        misaligned;

  assign PC_plus4       = PC + 32'd4;
  assign imem.imem_addr = PC;
  assign jalr_sum       = RS1 + Imm;

  // Jalr has priority over Jump, Jump over BrTaken; JALR drops bit 0 before the alignment check
  always_comb begin
    target = PC_plus4;
    if (Jalr) begin
      target = jalr_sum & ~32'h1;
    end else if (Jump) begin
      target = PC + Imm;
    end else if (BrTaken) begin
      target = PC + Imm;
    end
  end

  assign misaligned = (target[1:0] != 2'b00);

  always_comb begin
    state_next    = state;
    pc_next       = PC;
    trap_pc_next  = trap_pc;
    retired_next  = retired;
    imem.imem_req = 1'b0;
    instr_valid   = 1'b0;
    trap          = 1'b0;
    case (state)
      BOOT: begin
        state_next = FETCH;
      end
      FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          instr_valid = 1'b1;
          if (misaligned) begin
            trap         = 1'b1;
            pc_next      = TRAP_VEC;
            trap_pc_next = PC;
            state_next   = TRAP;
          end else begin
            pc_next      = target;
            retired_next = retired + 32'd1;
          end
        end
      end
      TRAP: begin
        state_next = FETCH;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      PC      <= RESET_PC;
      trap_pc <= 32'h0;
      retired <= 32'h0;
    end else begin
      state   <= state_next;
      PC      <= pc_next;
      trap_pc <= trap_pc_next;
      retired <= retired_next;
    end
  end

endmodule
